vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Raster timing controller that sequences the display datapath. It divides CLK into a pixel tick and runs horizontal and vertical position counters through SYNC, BACK_PORCH, DISPLAY and FRONT_PORCH phases. It drives the SYNCH_TIME/ENABLE inputs of the per-axis pixel counters and produces the HS/VS sync outputs, a display-active qualifier and a frame-start strobe. It sits between the board clock and the pixel-address and colour-output logic.

## Interface
- ClkDiv, 2: CLK cycles per pixel tick (≥1; 1 = tick every cycle)
- HPulse, 96 / HBack, 48 / HDisp, 640 / HFront, 16: horizontal phase lengths in ticks
- VPulse, 2 / VBack, 33 / VDisp, 480 / VFront, 10: vertical phase lengths in lines
- CntWidth, 10: position counter width; HTotal=HPulse+HBack+HDisp+HFront and VTotal must both be ≤ 2^CntWidth
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  synchronous active-low reset, sampled on CLK rising edge
- RUN  in  1  1 = timing advances; 0 = freeze
- H_SYNCH_TIME  out  CntWidth  horizontal position, 0..HTotal-1
- V_SYNCH_TIME  out  CntWidth  vertical position, 0..VTotal-1
- H_ENABLE  out  1  one-CLK pulse on every pixel tick
- V_ENABLE  out  1  one-CLK pulse on the tick where H wraps to 0
- H_STATE  out  2  0=SYNC, 1=BACK_PORCH, 2=DISPLAY, 3=FRONT_PORCH
- V_STATE  out  2  same encoding, vertical
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- DISP_ACTIVE  out  1  high when H_STATE and V_STATE are both DISPLAY
- FRAME_START  out  1  one-CLK pulse when both counters wrap to (0,0)

## Operation
- Divider DIV counts 0..ClkDiv-1 while RUN=1. A tick occurs on the cycle with DIV=ClkDiv-1. On that cycle DIV returns to 0.
- On a tick, H advances by 1. At HTotal-1, H wraps to 0 and V advances by 1. At VTotal-1, V wraps to 0.
- Phase decode per axis, with P=Pulse, B=Back, D=Disp:
  - pos < P: SYNC
  - pos < P+B: BACK_PORCH
  - pos < P+B+D: DISPLAY
  - otherwise: FRONT_PORCH
- HS=0 iff H_STATE=SYNC. VS=0 iff V_STATE=SYNC.
- All outputs are registered. They are decoded from next-state counter values, so every output agrees with H_SYNCH_TIME/V_SYNCH_TIME in the same cycle, with no one-cycle skew.
- H_ENABLE, V_ENABLE and FRAME_START are asserted in the cycle the new counter values appear. They are low on every other cycle.
- RUN=0:
  - DIV, H and V hold.
  - All pulse outputs are 0.
  - Level outputs hold.
  - When RUN returns to 1, DIV resumes from its held value.
- Counter arithmetic is unsigned, CntWidth bits. Wrap is by compare-to-Total-1, never by overflow.

## Timing
- Reset (RESET_N=0 at a rising edge, including mid-line or mid-frame): on the next edge the outputs are:
  - DIV=0, H_SYNCH_TIME=0, V_SYNCH_TIME=0
  - H_STATE=V_STATE=SYNC, HS=0, VS=0
  - H_ENABLE=V_ENABLE=FRAME_START=0, DISP_ACTIVE=0
- Reset has priority over RUN.
- First tick after reset release with RUN=1: ClkDiv cycles after the first edge with RESET_N=1, H=1.
- With default parameters a line is 800 ticks (1600 CLK) and a frame is 525 lines.
- Simultaneous H wrap and V wrap on one tick: H=0, V=0, and H_ENABLE, V_ENABLE and FRAME_START all pulse in the same cycle.
- ClkDiv=1: H_ENABLE stays high continuously while RUN=1.

## Test plan
- Reset mid-frame: ClkDiv=2, run to H=300, V=100, pulse RESET_N low for 1 cycle -> next edge shows H=0, V=0, HS=0, VS=0, all pulses 0. The first tick comes 2 cycles after release.
- Phase boundaries with small parameters: HPulse=2, HBack=1, HDisp=4, HFront=1, ClkDiv=1 -> H sequence 0..7 gives HS low at H=0,1 only and H_STATE=0,0,1,2,2,2,2,3. V_ENABLE pulses at H=0 and does not pulse at H=7.
- Frame wrap: VPulse=1, VBack=1, VDisp=2, VFront=1 with the same H parameters -> FRAME_START pulses once every 40 CLK, coincident with V_ENABLE and H_ENABLE. DISP_ACTIVE is high for exactly 8 cycles per frame.
- RUN freeze: deassert RUN at H=5 with DIV=1 for 10 cycles -> H stays 5, no pulses. After reassert, the tick occurs on the first cycle back (DIV was 1).
- Default VGA parameters, full frame -> 525×800 ticks. HS low is 96 ticks/line, VS low is 2 lines/frame, DISP_ACTIVE is high for 640×480 ticks.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// Raster timing controller: pixel-tick divider, horizontal/vertical position counters,
// phase decode, sync outputs and frame strobes, all registered from next-state values.
`timescale 1ns/1ps
module vga_timing_ctrl #(
    parameter int ClkDiv   = 2,
    parameter int HPulse   = 96,
    parameter int HBack    = 48,
    parameter int HDisp    = 640,
    parameter int HFront   = 16,
    parameter int VPulse   = 2,
    parameter int VBack    = 33,
    parameter int VDisp    = 480,
    parameter int VFront   = 10,
    parameter int CntWidth = 10
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                RUN,
    output logic [CntWidth-1:0] H_SYNCH_TIME,
    output logic [CntWidth-1:0] V_SYNCH_TIME,
    output logic                H_ENABLE,
    output logic                V_ENABLE,
    output logic [1:0]          H_STATE,
    output logic [1:0]          V_STATE,
    output logic                HS,
    output logic                VS,
    output logic                DISP_ACTIVE,
    output logic                FRAME_START
);

    localparam int HTotal = HPulse + HBack + HDisp + HFront;
    localparam int VTotal = VPulse + VBack + VDisp + VFront;
    localparam int DivW   = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int CW1    = CntWidth + 1;

    localparam logic [DivW-1:0]     DIV_LAST = DivW'(ClkDiv - 1);
    localparam logic [CntWidth-1:0] H_LAST   = CntWidth'(HTotal - 1);
    localparam logic [CntWidth-1:0] V_LAST   = CntWidth'(VTotal - 1);

    // Phase thresholds carry one extra bit so P+B+D == 2^CntWidth cannot alias to 0.
    localparam logic [CntWidth:0] H_B0 = CW1'(HPulse);
    localparam logic [CntWidth:0] H_B1 = CW1'(HPulse + HBack);
    localparam logic [CntWidth:0] H_B2 = CW1'(HPulse + HBack + HDisp);
    localparam logic [CntWidth:0] V_B0 = CW1'(VPulse);
    localparam logic [CntWidth:0] V_B1 = CW1'(VPulse + VBack);
    localparam logic [CntWidth:0] V_B2 = CW1'(VPulse + VBack + VDisp);

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_DISP  = 2'd2,
        PH_FRONT = 2'd3
    } phase_e;

    function automatic phase_e decode_phase(
        input logic [CntWidth-1:0] pos,
        input logic [CntWidth:0]   b0,
        input logic [CntWidth:0]   b1,
        input logic [CntWidth:0]   b2
    );
        logic [CntWidth:0] p;
        p = {1'b0, pos};
        if (p < b0)      return PH_SYNC;
        else if (p < b1) return PH_BACK;
        else if (p < b2) return PH_DISP;
        else             return PH_FRONT;
    endfunction

    logic [DivW-1:0]     r_div;
    logic [CntWidth-1:0] r_h;
    logic [CntWidth-1:0] r_v;
    logic                r_hen;
    logic                r_ven;
    logic                r_fs;
    phase_e              r_hstate;
    phase_e              r_vstate;
    logic                r_hs;
    logic                r_vs;
    logic                r_da;

    logic                w_tick;
    logic                w_hwrap;
    logic                w_vwrap;
    logic [DivW-1:0]     w_div_nxt;
    logic [CntWidth-1:0] w_h_nxt;
    logic [CntWidth-1:0] w_v_nxt;
    phase_e              w_hph_nxt;
    phase_e              w_vph_nxt;

    always_comb begin
        w_tick    = RUN && (r_div == DIV_LAST);
        w_hwrap   = w_tick && (r_h == H_LAST);
        w_vwrap   = w_hwrap && (r_v == V_LAST);
        w_div_nxt = r_div;
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (RUN) begin
            w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
        if (w_tick) begin
            w_h_nxt = w_hwrap ? '0 : r_h + 1'b1;
        end
        if (w_hwrap) begin
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end
        // Decode from next-state positions so level outputs line up with the counters.
        w_hph_nxt = decode_phase(w_h_nxt, H_B0, H_B1, H_B2);
        w_vph_nxt = decode_phase(w_v_nxt, V_B0, V_B1, V_B2);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_hen    <= 1'b0;
            r_ven    <= 1'b0;
            r_fs     <= 1'b0;
            r_hstate <= PH_SYNC;
            r_vstate <= PH_SYNC;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_da     <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_h      <= w_h_nxt;
            r_v      <= w_v_nxt;
            r_hen    <= w_tick;
            r_ven    <= w_hwrap;
            r_fs     <= w_vwrap;
            r_hstate <= w_hph_nxt;
            r_vstate <= w_vph_nxt;
            r_hs     <= (w_hph_nxt != PH_SYNC);
            r_vs     <= (w_vph_nxt != PH_SYNC);
            r_da     <= (w_hph_nxt == PH_DISP) && (w_vph_nxt == PH_DISP);
        end
    end

    assign H_SYNCH_TIME = r_h;
    assign V_SYNCH_TIME = r_v;
    assign H_ENABLE     = r_hen;
    assign V_ENABLE     = r_ven;
    assign FRAME_START  = r_fs;
    assign H_STATE      = r_hstate;
    assign V_STATE      = r_vstate;
    assign HS           = r_hs;
    assign VS           = r_vs;
    assign DISP_ACTIVE  = r_da;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three parameterisations checked every cycle against a
// tick-count model, plus directed checks with hand-computed values.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [3];
    logic       run   [3];
    logic [9:0] h_t   [3];
    logic [9:0] v_t   [3];
    logic [1:0] hst   [3];
    logic [1:0] vst   [3];
    logic       hen   [3];
    logic       ven   [3];
    logic       fs    [3];
    logic       hs    [3];
    logic       vs    [3];
    logic       da    [3];

    int checks   = 0;
    int failures = 0;

    // 0: tiny raster, tick every cycle (8 ticks/line, 5 lines/frame)
    vga_timing_ctrl #(.ClkDiv(1), .HPulse(2), .HBack(1), .HDisp(4), .HFront(1),
                      .VPulse(1), .VBack(1), .VDisp(2), .VFront(1), .CntWidth(10)) u_small (
        .CLK(clk), .RESET_N(rst_n[0]), .RUN(run[0]),
        .H_SYNCH_TIME(h_t[0]), .V_SYNCH_TIME(v_t[0]), .H_ENABLE(hen[0]), .V_ENABLE(ven[0]),
        .H_STATE(hst[0]), .V_STATE(vst[0]), .HS(hs[0]), .VS(vs[0]),
        .DISP_ACTIVE(da[0]), .FRAME_START(fs[0]));

    // 1: default VGA timing
    vga_timing_ctrl u_vga (
        .CLK(clk), .RESET_N(rst_n[1]), .RUN(run[1]),
        .H_SYNCH_TIME(h_t[1]), .V_SYNCH_TIME(v_t[1]), .H_ENABLE(hen[1]), .V_ENABLE(ven[1]),
        .H_STATE(hst[1]), .V_STATE(vst[1]), .HS(hs[1]), .VS(vs[1]),
        .DISP_ACTIVE(da[1]), .FRAME_START(fs[1]));

    // 2: VGA line, short frame, divide by 3
    vga_timing_ctrl #(.ClkDiv(3), .VPulse(2), .VBack(3), .VDisp(4), .VFront(1)) u_div3 (
        .CLK(clk), .RESET_N(rst_n[2]), .RUN(run[2]),
        .H_SYNCH_TIME(h_t[2]), .V_SYNCH_TIME(v_t[2]), .H_ENABLE(hen[2]), .V_ENABLE(ven[2]),
        .H_STATE(hst[2]), .V_STATE(vst[2]), .HS(hs[2]), .VS(vs[2]),
        .DISP_ACTIVE(da[2]), .FRAME_START(fs[2]));

    typedef struct {
        int h;
        int v;
        int hst;
        int vst;
        bit hen;
        bit ven;
        bit fs;
        bit hs;
        bit vs;
        bit da;
    } obs_t;

    // Model state: running cycles since reset, and whether the last edge advanced.
    longint m_n     [3];
    bit     m_ran   [3];
    bit     m_valid [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                m_n[i]     <= 0;
                m_ran[i]   <= 1'b0;
                m_valid[i] <= 1'b1;
            end else if (run[i]) begin
                m_n[i]   <= m_n[i] + 1;
                m_ran[i] <= 1'b1;
            end else begin
                m_ran[i] <= 1'b0;
            end
        end
    end

    function automatic int phase(input int pos, input int p, input int b, input int d);
        if (pos < p)         return 0;
        if (pos < p + b)     return 1;
        if (pos < p + b + d) return 2;
        return 3;
    endfunction

    function automatic obs_t model(input int cd, input int hp, input int hb, input int hd,
                                   input int hf, input int vp, input int vb, input int vd,
                                   input int vf, input longint n, input bit ran);
        obs_t   e;
        longint ticks;
        int     ht;
        int     vt;
        ht    = hp + hb + hd + hf;
        vt    = vp + vb + vd + vf;
        ticks = n / cd;
        e.h   = int'(ticks % ht);
        e.v   = int'((ticks / ht) % vt);
        e.hst = phase(e.h, hp, hb, hd);
        e.vst = phase(e.v, vp, vb, vd);
        e.hs  = (e.hst != 0);
        e.vs  = (e.vst != 0);
        e.da  = (e.hst == 2) && (e.vst == 2);
        e.hen = ran && ((n % cd) == 0);
        e.ven = e.hen && (e.h == 0);
        e.fs  = e.ven && (e.v == 0);
        return e;
    endfunction

    function automatic obs_t actual(input int i);
        obs_t a;
        a.h   = int'(h_t[i]);
        a.v   = int'(v_t[i]);
        a.hst = int'(hst[i]);
        a.vst = int'(vst[i]);
        a.hen = hen[i];
        a.ven = ven[i];
        a.fs  = fs[i];
        a.hs  = hs[i];
        a.vs  = vs[i];
        a.da  = da[i];
        return a;
    endfunction

    task automatic compare(input string nm, input obs_t e, input obs_t a);
        checks++;
        if (e.h != a.h || e.v != a.v || e.hst != a.hst || e.vst != a.vst || e.hen != a.hen ||
            e.ven != a.ven || e.fs != a.fs || e.hs != a.hs || e.vs != a.vs || e.da != a.da) begin
            failures++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hst=%0d vst=%0d hen=%0b ven=%0b fs=%0b hs=%0b vs=%0b da=%0b | want h=%0d v=%0d hst=%0d vst=%0d hen=%0b ven=%0b fs=%0b hs=%0b vs=%0b da=%0b",
                     nm, $time, a.h, a.v, a.hst, a.vst, a.hen, a.ven, a.fs, a.hs, a.vs, a.da,
                     e.h, e.v, e.hst, e.vst, e.hen, e.ven, e.fs, e.hs, e.vs, e.da);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Advance one clock and check every instance against the model.
    task automatic step();
        @(negedge clk);
        if (m_valid[0]) compare("model_small", model(1, 2, 1, 4, 1, 1, 1, 2, 1, m_n[0], m_ran[0]), actual(0));
        if (m_valid[1]) compare("model_vga", model(2, 96, 48, 640, 16, 2, 33, 480, 10, m_n[1], m_ran[1]), actual(1));
        if (m_valid[2]) compare("model_div3", model(3, 96, 48, 640, 16, 2, 3, 4, 1, m_n[2], m_ran[2]), actual(2));
    endtask

    initial begin
        int hst_exp [8];
        int cnt;
        int da_cnt;
        int ticks;
        int hs_lo;
        int vs_lines;
        hst_exp = '{0, 0, 1, 2, 2, 2, 2, 3};
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            run[i]   = 1'b1;
        end
        repeat (3) step();
        chk("reset_h", int'(h_t[1]), 0);
        chk("reset_v", int'(v_t[1]), 0);
        chk("reset_hs", int'(hs[1]), 0);
        chk("reset_vs", int'(vs[1]), 0);
        chk("reset_hen", int'(hen[1]), 0);

        rst_n[0] = 1'b1;
        rst_n[2] = 1'b1;

        // Second line of the tiny raster: phase boundaries and V_ENABLE placement
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            chk("small_h", int'(h_t[0]), i);
            chk("small_hstate", int'(hst[0]), hst_exp[i]);
            chk("small_hs", int'(hs[0]), (i >= 2) ? 1 : 0);
            chk("small_ven", int'(ven[0]), (i == 0) ? 1 : 0);
            chk("small_hen", int'(hen[0]), 1);
            step();
        end

        // Frame period and display-active count on the tiny raster
        cnt = 0;
        while (!fs[0] && cnt < 100) begin
            step();
            cnt++;
        end
        chk("small_fs_seen", int'(fs[0]), 1);
        chk("small_fs_ven", int'(ven[0]), 1);
        chk("small_fs_hen", int'(hen[0]), 1);
        cnt    = 0;
        da_cnt = 0;
        do begin
            da_cnt += int'(da[0]);
            step();
            cnt++;
        end while (!fs[0] && cnt < 100);
        chk("small_frame_period", cnt, 40);
        chk("small_da_per_frame", da_cnt, 8);

        // RUN freeze at H=5 with the divider at 1
        rst_n[1] = 1'b1;
        repeat (11) step();
        chk("freeze_pre_h", int'(h_t[1]), 5);
        chk("freeze_pre_hen", int'(hen[1]), 0);
        run[1] = 1'b0;
        repeat (10) begin
            step();
            chk("freeze_h", int'(h_t[1]), 5);
            chk("freeze_hen", int'(hen[1]), 0);
        end
        run[1] = 1'b1;
        step();
        chk("resume_h", int'(h_t[1]), 6);
        chk("resume_hen", int'(hen[1]), 1);

        // Reset in the middle of a frame
        cnt = 0;
        while (!(h_t[1] == 10'd300 && v_t[1] == 10'd2) && cnt < 8000) begin
            step();
            cnt++;
        end
        chk("midframe_reached", (h_t[1] == 10'd300 && v_t[1] == 10'd2) ? 1 : 0, 1);
        chk("midframe_vs", int'(vs[1]), 1);
        rst_n[1] = 1'b0;
        step();
        chk("midrst_h", int'(h_t[1]), 0);
        chk("midrst_v", int'(v_t[1]), 0);
        chk("midrst_hs", int'(hs[1]), 0);
        chk("midrst_vs", int'(vs[1]), 0);
        chk("midrst_pulses", int'(hen[1]) + int'(ven[1]) + int'(fs[1]) + int'(da[1]), 0);
        chk("midrst_states", int'(hst[1]) + int'(vst[1]), 0);
        rst_n[1] = 1'b1;
        step();
        chk("release1_h", int'(h_t[1]), 0);
        chk("release1_hen", int'(hen[1]), 0);
        step();
        chk("release2_h", int'(h_t[1]), 1);
        chk("release2_hen", int'(hen[1]), 1);

        // Full frame statistics, divide-by-3 instance
        cnt = 0;
        while (!fs[2] && cnt < 30000) begin
            step();
            cnt++;
        end
        chk("div3_fs_seen", int'(fs[2]), 1);
        cnt      = 0;
        ticks    = 0;
        hs_lo    = 0;
        da_cnt   = 0;
        vs_lines = 0;
        do begin
            if (hen[2]) begin
                ticks++;
                if (!hs[2]) hs_lo++;
                if (da[2]) da_cnt++;
            end
            if (ven[2] && !vs[2]) vs_lines++;
            step();
            cnt++;
        end while (!fs[2] && cnt < 30000);
        chk("div3_frame_clk", cnt, 24000);
        chk("div3_frame_ticks", ticks, 8000);
        chk("div3_hs_low_ticks", hs_lo, 960);
        chk("div3_vs_low_lines", vs_lines, 2);
        chk("div3_disp_ticks", da_cnt, 2560);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
